// File: rtl/hazard_perf_counters.sv
// -----------------------------------------------------------------------------
// hazard_perf_counters
// Performance counters fed by the hazard controller's per-cycle indications.
// Counts cycles and miss episodes in saturating counters, with a registered
// one-cycle-latency read port and a synchronous clear.
//
// Counter map:
//   0 total cycles        5 lw_hazard cycles
//   1 ic_miss cycles      6 dec_overload cycles
//   2 ic_miss episodes    7 ex_overload cycles
//   3 dc_miss cycles      8 if_stall cycles
//   4 dc_miss episodes    9 mem_stall cycles
//   addresses 10..15 read as 0
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              counting enable
//   clear           synchronous clear of all counters and sat
//   ic_miss .. mem_stall   per-cycle event inputs
//   rd_req, rd_addr read request and counter index
//   rd_ack, rd_data read response, valid one cycle after rd_req
//   sat             sticky flag: an increment hit a counter at all-ones
// -----------------------------------------------------------------------------
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             ic_miss,
    input  logic             dc_miss,
    input  logic             lw_hazard,
    input  logic             dec_overload,
    input  logic             ex_overload,
    input  logic             if_stall,
    input  logic             mem_stall,
    input  logic             rd_req,
    input  logic [3:0]       rd_addr,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             sat
);

    localparam int NUM_CNT = 10;

    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic             prev_ic_q, prev_dc_q;
    logic             sat_q, sat_d;
    logic             rd_ack_q;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] rd_sel;
    logic [NUM_CNT-1:0] hit;

    // Episodes use the previous-cycle sample, so a miss already high when
    // en rises is not counted as a new episode.
    always_comb begin
        hit    = '0;
        hit[0] = 1'b1;
        hit[1] = ic_miss;
        hit[2] = ic_miss & ~prev_ic_q;
        hit[3] = dc_miss;
        hit[4] = dc_miss & ~prev_dc_q;
        hit[5] = lw_hazard;
        hit[6] = dec_overload;
        hit[7] = ex_overload;
        hit[8] = if_stall;
        hit[9] = mem_stall;
    end

    // Clear wins over any same-cycle increment.
    always_comb begin
        sat_d = sat_q;
        for (int k = 0; k < NUM_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clear) begin
                cnt_d[k] = '0;
            end else if (en && hit[k]) begin
                if (cnt_q[k] == {CNT_W{1'b1}}) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
        if (clear) begin
            sat_d = 1'b0;
        end
    end

    // Read captures the pre-update value; unmapped addresses return 0.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_addr == 4'(k)) begin
                rd_sel = cnt_q[k];
            end
        end
        rd_data_d = rd_req ? rd_sel : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= '0;
            end
            prev_ic_q <= 1'b0;
            prev_dc_q <= 1'b0;
            sat_q     <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            prev_ic_q <= ic_miss;
            prev_dc_q <= dc_miss;
            sat_q     <= sat_d;
            rd_ack_q  <= rd_req;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_hazard_perf_counters.sv
module tb_hazard_perf_counters;

    localparam int CNT_W = 8;
    localparam int MAXV  = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0, clear = 1'b0;
    logic             ic_miss = 1'b0, dc_miss = 1'b0, lw_hazard = 1'b0;
    logic             dec_overload = 1'b0, ex_overload = 1'b0;
    logic             if_stall = 1'b0, mem_stall = 1'b0;
    logic             rd_req = 1'b0;
    logic [3:0]       rd_addr = 4'd0;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;
    logic             sat;

    hazard_perf_counters #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .ic_miss(ic_miss), .dc_miss(dc_miss), .lw_hazard(lw_hazard),
        .dec_overload(dec_overload), .ex_overload(ex_overload),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .sat(sat)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;

    // Reference model: plain integer counters updated by the event rules.
    int  m_cnt [10];
    bit  m_sat;
    bit  m_pic, m_pdc;
    int  exp_q [$];
    bit  exp_ack;
    int  last_data;
    bit  mon_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_sat = 0; m_pic = 0; m_pdc = 0;
        exp_q.delete();
        exp_ack = 0;
        last_data = 0;
    endtask

    // ev bits: 0 ic, 1 dc, 2 lw, 3 dec, 4 ex, 5 if, 6 mem
    task automatic step(input bit s_en, input bit s_clr, input bit [6:0] s_ev,
                        input bit s_req, input int s_addr);
        bit hit [10];
        @(negedge clk);
        en = s_en; clear = s_clr;
        ic_miss = s_ev[0]; dc_miss = s_ev[1]; lw_hazard = s_ev[2];
        dec_overload = s_ev[3]; ex_overload = s_ev[4];
        if_stall = s_ev[5]; mem_stall = s_ev[6];
        rd_req = s_req; rd_addr = 4'(s_addr);
        exp_ack = s_req;
        if (s_req) exp_q.push_back(s_addr < 10 ? m_cnt[s_addr] : 0);
        hit[0] = 1;
        hit[1] = s_ev[0];
        hit[2] = s_ev[0] && !m_pic;
        hit[3] = s_ev[1];
        hit[4] = s_ev[1] && !m_pdc;
        hit[5] = s_ev[2];
        hit[6] = s_ev[3];
        hit[7] = s_ev[4];
        hit[8] = s_ev[5];
        hit[9] = s_ev[6];
        if (s_clr) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_sat = 0;
        end else if (s_en) begin
            for (int k = 0; k < 10; k++) begin
                if (hit[k]) begin
                    if (m_cnt[k] == MAXV) m_sat = 1;
                    else m_cnt[k]++;
                end
            end
        end
        m_pic = s_ev[0];
        m_pdc = s_ev[1];
    endtask

    // Monitor: compares responses one time unit after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && mon_on) begin
                chk("rd_ack", 64'(rd_ack), 64'(exp_ack));
                if (rd_ack === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: got ack with no pending request at %0t", $time);
                    end else begin
                        last_data = exp_q.pop_front();
                        chk("rd_data", 64'(rd_data), 64'(last_data));
                    end
                end else begin
                    chk("rd_data_hold", 64'(rd_data), 64'(last_data));
                end
                chk("sat", 64'(sat), 64'(m_sat));
            end
        end
    end

    initial begin
        model_reset();
        mon_on = 0;
        #1;
        chk("reset_rd_ack", 64'(rd_ack), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_sat", 64'(sat), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1;

        // 100 idle enabled cycles, then read total cycles (expect 100)
        repeat (100) step(1, 0, 7'h00, 0, 0);
        step(1, 0, 7'h00, 1, 0);

        // Episodes: ic 3 high, 2 low, 4 high -> ctr1=7, ctr2=2
        step(0, 1, 7'h00, 0, 0);
        repeat (3) step(1, 0, 7'h01, 0, 0);
        repeat (2) step(1, 0, 7'h00, 0, 0);
        repeat (4) step(1, 0, 7'h01, 0, 0);
        step(1, 0, 7'h00, 1, 1);
        step(1, 0, 7'h00, 1, 2);
        // Miss already high when en rises: no new episode
        step(0, 0, 7'h00, 0, 0);
        repeat (2) step(0, 0, 7'h01, 0, 0);
        repeat (3) step(1, 0, 7'h01, 0, 0);
        step(1, 0, 7'h00, 1, 2);
        step(1, 0, 7'h00, 1, 1);

        // Saturation of mem_stall, then clear
        step(0, 1, 7'h00, 0, 0);
        repeat (300) step(1, 0, 7'h40, 0, 0);
        step(1, 0, 7'h00, 1, 9);
        step(1, 1, 7'h00, 0, 0);
        step(0, 0, 7'h00, 1, 9);

        // Clear / increment collision with same-edge read
        repeat (3) step(1, 0, 7'h02, 0, 0);
        step(1, 1, 7'h02, 1, 3);
        step(0, 0, 7'h00, 1, 3);

        // Unmapped addresses, then back-to-back reads of 6 and 7
        step(0, 0, 7'h00, 1, 10);
        step(0, 0, 7'h00, 1, 15);
        repeat (5) step(1, 0, 7'h08, 0, 0);
        repeat (2) step(1, 0, 7'h10, 0, 0);
        step(1, 0, 7'h18, 0, 0);
        step(1, 0, 7'h00, 1, 6);
        step(1, 0, 7'h00, 1, 7);

        // Randomized traffic
        repeat (3000) begin
            step(($urandom % 8) != 0, ($urandom % 150) == 0, 7'($urandom),
                 ($urandom % 2) == 1, int'($urandom % 16));
        end

        // Asynchronous reset with a read in flight
        repeat (20) step(1, 0, 7'h7f, 0, 0);
        step(1, 0, 7'h7f, 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_rd_ack", 64'(rd_ack), 64'd0);
        chk("async_rst_rd_data", 64'(rd_data), 64'd0);
        chk("async_rst_sat", 64'(sat), 64'd0);
        model_reset();
        @(negedge clk);
        en = 0; clear = 0; rd_req = 0;
        ic_miss = 0; dc_miss = 0; lw_hazard = 0; dec_overload = 0;
        ex_overload = 0; if_stall = 0; mem_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) step(0, 0, 7'h00, 1, a);

        step(0, 0, 7'h00, 0, 0);
        step(0, 0, 7'h00, 0, 0);
        @(posedge clk);
        #2;
        mon_on = 0;
        chk("pending_reads", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
